// File: rtl/fetch_ctrl_pkg.sv
// Shared state encoding, size defaults and small decode helpers for the
// instruction-fetch sequencer.
package fetch_ctrl_pkg;

   localparam int unsigned TIMEOUT_DEF = 15;
   localparam int unsigned CNT_W_DEF   = 32;
   localparam int unsigned WAIT_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EXEC  = 3'd3,
      ST_HALT  = 3'd4,
      ST_FAULT = 3'd5
   } state_e;

   // Sequencing is in progress whenever an instruction is being fetched or executed.
   function automatic logic state_busy(input state_e st);
      return (st == ST_FETCH) || (st == ST_WAIT) || (st == ST_EXEC);
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch/datapath handshake bundle between the sequencer (master) and the
// instruction memory plus datapath side (slave).
interface fetch_ctrl_if;

   logic imem_req;
   logic imem_ready;
   logic ir_load;
   logic instr_valid;
   logic pc_load;
   logic pc_src;
   logic branch_taken;
   logic halt_instr;
   logic stall;

   modport master (
      output imem_req,
      output ir_load,
      output instr_valid,
      output pc_load,
      output pc_src,
      input  imem_ready,
      input  branch_taken,
      input  halt_instr,
      input  stall
   );

   modport slave (
      input  imem_req,
      input  ir_load,
      input  instr_valid,
      input  pc_load,
      input  pc_src,
      output imem_ready,
      output branch_taken,
      output halt_instr,
      output stall
   );

endinterface

// File: rtl/fetch_wait_timer.sv
// Counts memory wait cycles and flags the cycle on which the TIMEOUT-th
// consecutive wait cycle completes without data.
module fetch_wait_timer
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic arst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [WAIT_W:0] LIMIT = TIMEOUT[WAIT_W:0];

   logic [WAIT_W-1:0] count_r;
   logic [WAIT_W:0]   count_inc_s;

   // Wait-cycle counter; clear has priority over counting.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable) begin
         count_r <= count_inc_s[WAIT_W-1:0];
      end else begin
         count_r <= count_r;
      end
   end

   // The current cycle is the TIMEOUT-th wait when the incremented count reaches the limit.
   always_comb begin
      count_inc_s = {1'b0, count_r} + {{WAIT_W{1'b0}}, 1'b1};
      if (enable) begin
         expired = (count_inc_s == LIMIT);
      end else begin
         expired = 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch/execute sequencer: drives the fetch handshake, PC update
// strobes and a retired-instruction count, with a sticky fetch-timeout fault.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   fetch_ctrl_if.master     bus,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   state_e           state_r;
   state_e           next_state_s;
   logic             timer_clear_s;
   logic             timer_enable_s;
   logic             timer_expired_s;
   logic             retire_s;
   logic [CNT_W-1:0] retired_r;

   fetch_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .arst    (arst),
      .clear   (timer_clear_s),
      .enable  (timer_enable_s),
      .expired (timer_expired_s)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         retired_r <= '0;
      end else if (retire_s) begin
         retired_r <= retired_r + CNT_W'(1'b1);
      end else begin
         retired_r <= retired_r;
      end
   end

   // Next-state and strobe decode; EXEC priority is stall, then halt, then branch.
   always_comb begin
      next_state_s    = state_r;
      bus.imem_req    = 1'b0;
      bus.ir_load     = 1'b0;
      bus.instr_valid = 1'b0;
      bus.pc_load     = 1'b0;
      bus.pc_src      = 1'b0;
      timer_clear_s   = 1'b0;
      timer_enable_s  = 1'b0;
      retire_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_load  = 1'b1;
               next_state_s = ST_EXEC;
            end else begin
               timer_clear_s = 1'b1;
               next_state_s  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            bus.imem_req   = 1'b1;
            timer_enable_s = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_load  = 1'b1;
               next_state_s = ST_EXEC;
            end else if (timer_expired_s) begin
               next_state_s = ST_FAULT;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_EXEC: begin
            bus.instr_valid = 1'b1;
            if (bus.stall) begin
               next_state_s = ST_EXEC;
            end else if (bus.halt_instr) begin
               bus.pc_load  = 1'b1;
               bus.pc_src   = 1'b0;
               retire_s     = 1'b1;
               next_state_s = ST_HALT;
            end else begin
               bus.pc_load  = 1'b1;
               bus.pc_src   = bus.branch_taken;
               retire_s     = 1'b1;
               next_state_s = ST_FETCH;
            end
         end
         ST_HALT: begin
            if (start) begin
               next_state_s = ST_FETCH;
            end else begin
               next_state_s = ST_HALT;
            end
         end
         ST_FAULT: begin
            next_state_s = ST_FAULT;
         end
         default: begin
            // An unreachable encoding is treated as a fault so it cannot run silently.
            next_state_s = ST_FAULT;
         end
      endcase
   end

   // Status flags decoded directly from the state register.
   always_comb begin
      busy    = state_busy(state_r);
      halted  = (state_r == ST_HALT);
      fault   = (state_r == ST_FAULT);
      retired = retired_r;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl, built with TIMEOUT=4 and a
// 4-bit retired counter so timeout and wrap-around are reachable quickly.
module tb_fetch_ctrl;

   logic       clk;
   logic       arst;
   logic       start;
   logic       busy;
   logic       halted;
   logic       fault;
   logic [3:0] retired;
   logic [7:0] obs;
   int         errors;
   int         checks;

   // obs = {imem_req, ir_load, instr_valid, pc_load, pc_src, busy, halted, fault}
   localparam logic [7:0] V_IDLE      = 8'b0000_0000;
   localparam logic [7:0] V_REQ       = 8'b1000_0100;
   localparam logic [7:0] V_FETCH_RDY = 8'b1100_0100;
   localparam logic [7:0] V_EXEC_STL  = 8'b0010_0100;
   localparam logic [7:0] V_EXEC_SEQ  = 8'b0011_0100;
   localparam logic [7:0] V_EXEC_BR   = 8'b0011_1100;
   localparam logic [7:0] V_HALT      = 8'b0000_0010;
   localparam logic [7:0] V_FAULT     = 8'b0000_0001;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .TIMEOUT (4),
      .CNT_W   (4)
   ) dut (
      .clk     (clk),
      .arst    (arst),
      .start   (start),
      .bus     (bus),
      .busy    (busy),
      .halted  (halted),
      .fault   (fault),
      .retired (retired)
   );

   assign obs = {bus.imem_req, bus.ir_load, bus.instr_valid, bus.pc_load,
                 bus.pc_src, busy, halted, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dp(input logic rdy, input logic br, input logic hlt, input logic stl);
      bus.imem_ready   = rdy;
      bus.branch_taken = br;
      bus.halt_instr   = hlt;
      bus.stall        = stl;
      #1;
   endtask

   // Reset, then sample start once so the DUT sits in FETCH on return.
   task automatic restart();
      start = 1'b0;
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      arst = 1'b0;
      #2;
      arst = 1'b1;
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1; start = 1'b0;
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      arst = 1'b0;
      #1;
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset_outs: got %b want %b", obs, V_IDLE); end
      checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
      start = 1'b1;
      cyc();
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, V_IDLE); end
      #2; arst = 1'b1; start = 1'b0;
      cyc();
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL idle_no_start: got %b want %b", obs, V_IDLE); end
      start = 1'b1; #1;
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL idle_start_cycle: got %b want %b", obs, V_IDLE); end
      cyc(); start = 1'b0; #1;
      checks++; if (obs !== V_REQ) begin errors++; $display("FAIL first_fetch: got %b want %b", obs, V_REQ); end
   endtask

   task automatic test_stream();
      restart();
      set_dp(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (obs !== V_FETCH_RDY) begin errors++; $display("FAIL stream_fetch[%0d]: got %b want %b", i, obs, V_FETCH_RDY); end
         cyc();
         checks++; if (obs !== V_EXEC_SEQ) begin errors++; $display("FAIL stream_exec[%0d]: got %b want %b", i, obs, V_EXEC_SEQ); end
         checks++; if (retired !== 4'(i)) begin errors++; $display("FAIL stream_retired[%0d]: got %0d want %0d", i, retired, i); end
         cyc();
      end
      checks++; if (retired !== 4'd3) begin errors++; $display("FAIL stream_total: got %0d want 3", retired); end
   endtask

   task automatic test_wait();
      restart();
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== V_REQ) begin errors++; $display("FAIL wait_fetch: got %b want %b", obs, V_REQ); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++; if (obs !== V_REQ) begin errors++; $display("FAIL wait_req[%0d]: got %b want %b", i, obs, V_REQ); end
      end
      cyc();
      bus.imem_ready = 1'b1; #1;
      checks++; if (obs !== V_FETCH_RDY) begin errors++; $display("FAIL wait_ready: got %b want %b", obs, V_FETCH_RDY); end
      cyc();
      bus.imem_ready = 1'b0; #1;
      checks++; if (obs !== V_EXEC_SEQ) begin errors++; $display("FAIL wait_exec: got %b want %b", obs, V_EXEC_SEQ); end
   endtask

   task automatic test_ready_at_limit();
      restart();
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
      end
      cyc();
      bus.imem_ready = 1'b1; #1;
      checks++; if (obs !== V_FETCH_RDY) begin errors++; $display("FAIL limit_ready_wins: got %b want %b", obs, V_FETCH_RDY); end
      cyc();
      bus.imem_ready = 1'b0; #1;
      checks++; if (obs !== V_EXEC_SEQ) begin errors++; $display("FAIL limit_exec: got %b want %b", obs, V_EXEC_SEQ); end
   endtask

   task automatic test_timeout();
      restart();
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++; if (obs !== V_REQ) begin errors++; $display("FAIL timeout_wait[%0d]: got %b want %b", i, obs, V_REQ); end
      end
      cyc();
      checks++; if (obs !== V_FAULT) begin errors++; $display("FAIL timeout_fault: got %b want %b", obs, V_FAULT); end
      for (int i = 0; i < 4; i++) begin
         start = ~start;
         bus.imem_ready = 1'b1;
         cyc();
         checks++; if (obs !== V_FAULT) begin errors++; $display("FAIL fault_sticky[%0d]: got %b want %b", i, obs, V_FAULT); end
      end
      start = 1'b0;
      bus.imem_ready = 1'b0;
      arst = 1'b0; #1;
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL fault_async_clear: got %b want %b", obs, V_IDLE); end
      #2; arst = 1'b1;
      cyc();
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL fault_idle_after: got %b want %b", obs, V_IDLE); end
   endtask

   task automatic test_stall_branch();
      restart();
      set_dp(1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      start = 1'b1;
      set_dp(1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if (obs !== V_EXEC_STL) begin errors++; $display("FAIL stall_1: got %b want %b", obs, V_EXEC_STL); end
      cyc();
      checks++; if (obs !== V_EXEC_STL) begin errors++; $display("FAIL stall_2: got %b want %b", obs, V_EXEC_STL); end
      checks++; if (retired !== 4'd0) begin errors++; $display("FAIL stall_retired: got %0d want 0", retired); end
      cyc();
      start = 1'b0;
      set_dp(1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (obs !== V_EXEC_BR) begin errors++; $display("FAIL branch_exec: got %b want %b", obs, V_EXEC_BR); end
      cyc();
      checks++; if (retired !== 4'd1) begin errors++; $display("FAIL branch_retired: got %0d want 1", retired); end
      checks++; if (obs !== V_REQ) begin errors++; $display("FAIL branch_refetch: got %b want %b", obs, V_REQ); end
   endtask

   task automatic test_halt();
      restart();
      set_dp(1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      set_dp(1'b0, 1'b1, 1'b1, 1'b1);
      checks++; if (obs !== V_EXEC_STL) begin errors++; $display("FAIL halt_stall_first: got %b want %b", obs, V_EXEC_STL); end
      cyc();
      set_dp(1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (obs !== V_EXEC_SEQ) begin errors++; $display("FAIL halt_exec: got %b want %b", obs, V_EXEC_SEQ); end
      cyc();
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== V_HALT) begin errors++; $display("FAIL halt_state: got %b want %b", obs, V_HALT); end
      checks++; if (retired !== 4'd1) begin errors++; $display("FAIL halt_retired: got %0d want 1", retired); end
      cyc();
      checks++; if (obs !== V_HALT) begin errors++; $display("FAIL halt_hold: got %b want %b", obs, V_HALT); end
      start = 1'b1; #1;
      checks++; if (obs !== V_HALT) begin errors++; $display("FAIL halt_start_cycle: got %b want %b", obs, V_HALT); end
      cyc();
      start = 1'b0; #1;
      checks++; if (obs !== V_REQ) begin errors++; $display("FAIL halt_resume: got %b want %b", obs, V_REQ); end
   endtask

   task automatic test_wrap();
      restart();
      set_dp(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i <= 17; i++) begin
         checks++; if (retired !== 4'(i)) begin errors++; $display("FAIL wrap_retired[%0d]: got %0d want %0d", i, retired, i % 16); end
         cyc();
         cyc();
      end
   endtask

   task automatic test_reset_in_wait();
      restart();
      set_dp(1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      cyc();
      set_dp(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (retired !== 4'd1) begin errors++; $display("FAIL rw_pre_retired: got %0d want 1", retired); end
      cyc();
      checks++; if (obs !== V_REQ) begin errors++; $display("FAIL rw_in_wait: got %b want %b", obs, V_REQ); end
      #2; arst = 1'b0; #1;
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL rw_async: got %b want %b", obs, V_IDLE); end
      checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rw_retired: got %0d want 0", retired); end
      cyc();
      #2; arst = 1'b1; bus.imem_ready = 1'b1;
      cyc();
      checks++; if (obs !== V_IDLE) begin errors++; $display("FAIL rw_idle_after: got %b want %b", obs, V_IDLE); end
      start = 1'b1;
      cyc();
      start = 1'b0; #1;
      checks++; if (obs !== V_FETCH_RDY) begin errors++; $display("FAIL rw_refetch: got %b want %b", obs, V_FETCH_RDY); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_stream();
      test_wait();
      test_ready_at_limit();
      test_timeout();
      test_stall_branch();
      test_halt();
      test_wrap();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
